bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//   Parametrised multi-digit BCD down-counter for the irrigation timer; supersedes single-digit 9->0 cells.
//   Loads a BCD preset, decrements once per qualified tick, and flags expiry with a one-cycle done pulse.
//   Adds pause, clear, per-digit clamping and optional auto-reload for periodic watering cycles.
//   Sits between the 1 Hz tick generator and the valve-control FSM; count drives the display decoders.
// PARAMETERS
//   DIGITS        2  number of BCD digits (1..4); digit 0 is least significant
//   TOP_DIGIT_MAX 9  max legal value of digit DIGITS-1 (5 for a seconds/minutes tens digit)
//   AUTO_RELOAD   0  1 = reload preset on expiry and keep running; 0 = stop at zero
// PORTS
//   clock       in   1          rising-edge clock
//   reset_n     in   1          asynchronous active-low reset
//   clear       in   1          synchronous abort: count<=0, go IDLE, no done pulse
//   load        in   1          capture load_value into count and reload register
//   load_value  in   4*DIGITS   BCD preset
//   tick        in   1          one-cycle count qualifier (e.g. 1 Hz strobe)
//   pause       in   1          level; freezes counting while high
//   count       out  4*DIGITS   current BCD value
//   running     out  1          1 in RUN state
//   paused      out  1          1 in HOLD state
//   zero        out  1          combinational: count == 0
//   done        out  1          registered one-cycle expiry pulse
// BEHAVIOUR
// - Reset (reset_n=0, async): count=0, reload register=0, state=IDLE, running=0, paused=0, done=0.
// - States: IDLE, RUN, HOLD. All updates on rising clock; done defaults to 0 every cycle.
// - Priority per cycle: clear > load > pause > tick.
// - clear: count<=0, state<=IDLE, reload register unchanged, done=0.
// - load: each digit >9 clamps to 9; top digit >TOP_DIGIT_MAX clamps to TOP_DIGIT_MAX;
//   clamped value written to count and reload register. Nonzero -> RUN (HOLD if pause=1);
//   zero -> IDLE, no done. Load accepted in any state, including mid-count.
// - RUN, pause=1: -> HOLD, tick in that cycle ignored. HOLD, pause=0: -> RUN next cycle; ticks in HOLD ignored.
// - RUN, tick=1, pause=0: BCD decrement by 1; digit i at 0 wraps to 9 and borrows into digit i+1;
//   top digit never wraps (expiry intercepts). Result always valid BCD, no binary codes A-F.
// - Expiry: tick in RUN with count==1: done<=1 same edge;
//   AUTO_RELOAD=0: count<=0, state<=IDLE. AUTO_RELOAD=1: count<=reload register, stay RUN.
//   Auto-reload period = preset ticks exactly; done fires once per period.
// - IDLE: ticks ignored, count held. HOLD: count held, done never asserted.
// - tick is not latched: a tick coincident with load/clear/pause is dropped.
// - Latency: count changes on the edge that samples tick; done aligned with count reaching 0/reload.
// - reset_n asserted mid-count aborts immediately; no done pulse on reset or release.
// TESTING
//   T1 DIGITS=2, load 0x12, 12 ticks -> count 11,10,09..01,00; done=1 only on 12th tick edge; IDLE.
//   T2 load 0x10, 1 tick -> count 0x09 (borrow, digit0 wraps to 9); zero=0, done=0.
//   T3 load 0x05, 2 ticks, pause=1 with 3 ticks, pause=0, 3 ticks -> 03 held in HOLD, then 00, done once.
//   T4 AUTO_RELOAD=1, load 0x03, 7 ticks -> 02,01,03,02,01,03,02; done on ticks 3 and 6; running stays 1.
//   T5 TOP_DIGIT_MAX=5, load 0x9C -> count 0x59 (both digits clamped); load 0x00 -> IDLE, no done.
//   T6 load 0x40, tick+load 0x07 same cycle -> count 07; reset_n=0 mid-count -> count 00, done 0, IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// bcd_countdown_timer
//
// Multi-digit BCD down-counter for the irrigation timer. A BCD preset is
// loaded (with per-digit clamping), the value is decremented once per
// qualified tick, and expiry is flagged with a registered one-cycle done
// pulse. Supports pause (HOLD state), synchronous clear and optional
// auto-reload for periodic watering cycles.
//
// Parameters
//   DIGITS         number of BCD digits (1..4); digit 0 is least significant
//   TOP_DIGIT_MAX  largest legal value of the most significant digit
//   AUTO_RELOAD    1: reload preset on expiry and keep running; 0: stop at 0
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   clear       in   synchronous abort: count <= 0, go IDLE, no done pulse
//   load        in   capture clamped load_value into count and reload register
//   load_value  in   BCD preset, 4*DIGITS bits
//   tick        in   one-cycle count qualifier (e.g. 1 Hz strobe)
//   pause       in   level; freezes counting while high
//   count       out  current BCD value, 4*DIGITS bits
//   running     out  1 in RUN state
//   paused      out  1 in HOLD state
//   zero        out  combinational: count == 0
//   done        out  registered one-cycle expiry pulse
//
// Per-cycle priority: clear > load > pause > tick. A tick that coincides
// with clear, load or pause is dropped, never remembered.
// -----------------------------------------------------------------------------
module bcd_countdown_timer #(
  parameter int DIGITS        = 2,
  parameter int TOP_DIGIT_MAX = 9,
  parameter bit AUTO_RELOAD   = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                tick,
  input  logic                pause,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                paused,
  output logic                zero,
  output logic                done
);

  localparam int W = 4 * DIGITS;

  // A top-digit limit above 9 would allow non-BCD codes, so cap it at 9.
  localparam logic [3:0] TOP_MAX =
    (TOP_DIGIT_MAX > 9) ? 4'd9 : 4'(TOP_DIGIT_MAX);

  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [W-1:0]   reload;
  logic [W-1:0]   reload_next;
  logic [W-1:0]   count_next;
  logic           done_next;
  logic [W-1:0]   load_clamped;
  logic [W-1:0]   count_dec;

  // Force every digit into legal range: lower digits to 9, the top digit to
  // TOP_MAX. Guarantees the counter never holds a code A-F.
  function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] value);
    logic [W-1:0] result;
    logic [3:0]   digit;
    logic [3:0]   limit;
    result = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      limit = (i == DIGITS - 1) ? TOP_MAX : 4'd9;
      result[4*i +: 4] = (digit > limit) ? limit : digit;
    end
    return result;
  endfunction

  // BCD decrement by one. A digit at 0 wraps to 9 and passes the borrow up.
  // Only called with count >= 2, so the top digit never wraps.
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] value);
    logic [W-1:0] result;
    logic [3:0]   digit;
    logic         borrow;
    result = value;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[4*i +: 4];
      if (borrow) begin
        if (digit == 4'd0) begin
          result[4*i +: 4] = 4'd9;
        end else begin
          result[4*i +: 4] = digit - 4'd1;
          borrow           = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign load_clamped = clamp_bcd(load_value);
  assign count_dec    = dec_bcd(count);

  // Next-state / datapath logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    done_next   = 1'b0;

    if (clear) begin
      count_next = '0;
      state_next = IDLE;
    end else if (load) begin
      count_next  = load_clamped;
      reload_next = load_clamped;
      if (load_clamped == '0) begin
        state_next = IDLE;
      end else begin
        state_next = pause ? HOLD : RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (pause) begin
            state_next = HOLD;
          end else if (tick) begin
            if (count == ONE) begin
              // Expiry: done rises on the same edge count reaches 0/reload.
              done_next = 1'b1;
              if (AUTO_RELOAD) begin
                count_next = reload;
              end else begin
                count_next = '0;
                state_next = IDLE;
              end
            end else begin
              count_next = count_dec;
            end
          end
        end
        HOLD: begin
          if (!pause) begin
            state_next = RUN;
          end
        end
        IDLE: begin
          // Ticks ignored, count held.
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      done   <= done_next;
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == HOLD);
  assign zero    = (count == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_countdown_timer
//
// Two 2-digit instances share one stimulus stream:
//   dut_a: TOP_DIGIT_MAX=9, AUTO_RELOAD=0 (stop at zero)
//   dut_b: TOP_DIGIT_MAX=5, AUTO_RELOAD=1 (periodic)
// A behavioural model keeps each counter as a plain decimal integer plus a
// run/hold flag pair and converts to BCD only for comparison.
// -----------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  logic       clock;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic       tick;
  logic       pause;

  logic [7:0] count_a;
  logic       running_a, paused_a, zero_a, done_a;
  logic [7:0] count_b;
  logic       running_b, paused_b, zero_b, done_b;

  int checks   = 0;
  int failures = 0;

  bcd_countdown_timer #(.DIGITS(2), .TOP_DIGIT_MAX(9), .AUTO_RELOAD(1'b0)) dut_a (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .tick       (tick),
    .pause      (pause),
    .count      (count_a),
    .running    (running_a),
    .paused     (paused_a),
    .zero       (zero_a),
    .done       (done_a)
  );

  bcd_countdown_timer #(.DIGITS(2), .TOP_DIGIT_MAX(5), .AUTO_RELOAD(1'b1)) dut_b (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .tick       (tick),
    .pause      (pause),
    .count      (count_b),
    .running    (running_b),
    .paused     (paused_b),
    .zero       (zero_b),
    .done       (done_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Reference model: decimal value, reload value, run/hold flags, done pulse.
  // ---------------------------------------------------------------------------
  int top_max  [2] = '{9, 5};
  bit auto_rel [2] = '{1'b0, 1'b1};
  int m_cnt    [2];
  int m_rel    [2];
  bit m_run    [2];
  bit m_hold   [2];
  bit m_done   [2];

  function automatic int clamp_val(input logic [7:0] v, input int top);
    int d0;
    int d1;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    if (d0 > 9) d0 = 9;
    if (d1 > top) d1 = top;
    return d1 * 10 + d0;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]  = 0;
      m_rel[k]  = 0;
      m_run[k]  = 1'b0;
      m_hold[k] = 1'b0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    int lc;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      lc = clamp_val(load_value, top_max[k]);
      if (clear) begin
        m_cnt[k]  = 0;
        m_run[k]  = 1'b0;
        m_hold[k] = 1'b0;
      end else if (load) begin
        m_cnt[k]  = lc;
        m_rel[k]  = lc;
        m_run[k]  = (lc != 0) && !pause;
        m_hold[k] = (lc != 0) && pause;
      end else if (m_run[k]) begin
        if (pause) begin
          m_run[k]  = 1'b0;
          m_hold[k] = 1'b1;
        end else if (tick) begin
          if (m_cnt[k] == 1) begin
            m_done[k] = 1'b1;
            if (auto_rel[k]) begin
              m_cnt[k] = m_rel[k];
            end else begin
              m_cnt[k] = 0;
              m_run[k] = 1'b0;
            end
          end else begin
            m_cnt[k] = m_cnt[k] - 1;
          end
        end
      end else if (m_hold[k]) begin
        if (!pause) begin
          m_hold[k] = 1'b0;
          m_run[k]  = 1'b1;
        end
      end
    end
  endtask

  // Packed snapshot {count, running, paused, zero, done}.
  function automatic logic [11:0] obs(input int k);
    if (k == 0) return {count_a, running_a, paused_a, zero_a, done_a};
    return {count_b, running_b, paused_b, zero_b, done_b};
  endfunction

  function automatic logic [11:0] exp_v(input int k);
    return {to_bcd(m_cnt[k]), m_run[k], m_hold[k], (m_cnt[k] == 0), m_done[k]};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle 1 ns.
  task automatic cycle(input logic c, input logic l, input logic [7:0] lv,
                       input logic t, input logic p);
    clear      = c;
    load       = l;
    load_value = lv;
    tick       = t;
    pause      = p;
    @(posedge clock);
    model_update();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    clear = 1'b0; load = 1'b1; load_value = 8'h45; tick = 1'b1; pause = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    checks++;
    if ({count_a, running_a, paused_a, zero_a, done_a} !== 12'h002) begin
      failures++;
      $display("FAIL reset_a got=%h exp=%h", obs(0), 12'h002);
    end
    checks++;
    if ({count_b, running_b, paused_b, zero_b, done_b} !== 12'h002) begin
      failures++;
      $display("FAIL reset_b got=%h exp=%h", obs(1), 12'h002);
    end
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_v(k)) begin
        failures++;
        $display("FAIL reset_idle_tick dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
      end
    end
  endtask

  // T1: load 12, twelve ticks down to 00, done only on the last.
  task automatic test_countdown();
    cycle(1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'h12 || running_a !== 1'b1) begin
      failures++;
      $display("FAIL t1_load got=%h/%b exp=12/1", count_a, running_a);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (count_a !== to_bcd(11 - i) || done_a !== (i == 11)) begin
        failures++;
        $display("FAIL t1_tick%0d got=%h/%b exp=%h/%b", i, count_a, done_a,
                 to_bcd(11 - i), (i == 11));
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_v(k)) begin
          failures++;
          $display("FAIL t1_model dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
        end
      end
    end
    checks++;
    if (running_a !== 1'b0 || zero_a !== 1'b1) begin
      failures++;
      $display("FAIL t1_idle got=%b/%b exp=0/1", running_a, zero_a);
    end
  endtask

  // T2: borrow across digits, then clear.
  task automatic test_borrow();
    cycle(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count_a !== 8'h09 || zero_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL t2_borrow got=%h/%b/%b exp=09/0/0", count_a, zero_a, done_a);
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_v(k)) begin
        failures++;
        $display("FAIL t2_clear dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
      end
    end
    checks++;
    if (count_a !== 8'h00 || running_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL t2_clear_a got=%h/%b/%b exp=00/0/0", count_a, running_a, done_a);
    end
  endtask

  // T3: pause holds the count and drops ticks; resume finishes with one done.
  task automatic test_pause();
    int dones;
    cycle(1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (count_a !== 8'h03 || paused_a !== 1'b1 || running_a !== 1'b0 ||
          done_a !== 1'b0) begin
        failures++;
        $display("FAIL t3_hold%0d got=%h p=%b r=%b d=%b exp=03 p=1 r=0 d=0",
                 i, count_a, paused_a, running_a, done_a);
      end
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (running_a !== 1'b1 || paused_a !== 1'b0 || count_a !== 8'h03) begin
      failures++;
      $display("FAIL t3_resume got=%h r=%b p=%b exp=03 r=1 p=0", count_a, running_a, paused_a);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      if (done_a === 1'b1) dones++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_v(k)) begin
          failures++;
          $display("FAIL t3_model dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
        end
      end
    end
    checks++;
    if (count_a !== 8'h00 || dones != 1) begin
      failures++;
      $display("FAIL t3_end got=%h dones=%0d exp=00 dones=1", count_a, dones);
    end
  endtask

  // T4: auto-reload period equals preset; done on ticks 3 and 6.
  task automatic test_auto_reload();
    logic [7:0] seq [7];
    seq = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
    cycle(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (count_b !== seq[i] || done_b !== (i == 2 || i == 5) || running_b !== 1'b1) begin
        failures++;
        $display("FAIL t4_tick%0d got=%h d=%b r=%b exp=%h d=%b r=1", i, count_b,
                 done_b, running_b, seq[i], (i == 2 || i == 5));
      end
      checks++;
      if (obs(0) !== exp_v(0)) begin
        failures++;
        $display("FAIL t4_model dut0 got=%h exp=%h", obs(0), exp_v(0));
      end
    end
  endtask

  // T5: clamping of both digits; loading zero goes IDLE without done.
  task automatic test_clamp();
    cycle(1'b0, 1'b1, 8'h9C, 1'b0, 1'b0);
    checks++;
    if (count_b !== 8'h59 || count_a !== 8'h99) begin
      failures++;
      $display("FAIL t5_clamp got=%h/%h exp=59/99", count_b, count_a);
    end
    cycle(1'b0, 1'b1, 8'hF3, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_v(k)) begin
        failures++;
        $display("FAIL t5_load_pause dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
      end
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count_b !== 8'h00 || running_b !== 1'b0 || paused_b !== 1'b0 ||
        done_b !== 1'b0 || zero_b !== 1'b1) begin
      failures++;
      $display("FAIL t5_zero got=%h r=%b p=%b d=%b z=%b exp=00 r=0 p=0 d=0 z=1",
               count_b, running_b, paused_b, done_b, zero_b);
    end
  endtask

  // T6: load beats a coincident tick; async reset mid-count.
  task automatic test_load_priority();
    cycle(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h07, 1'b1, 1'b0);
    checks++;
    if (count_a !== 8'h07 || count_b !== 8'h07) begin
      failures++;
      $display("FAIL t6_load_tick got=%h/%h exp=07/07", count_a, count_b);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({count_a, running_a, done_a} !== 10'h000 || {count_b, running_b, done_b} !== 10'h000) begin
      failures++;
      $display("FAIL t6_async_reset got=%h/%h exp=000/000",
               {count_a, running_a, done_a}, {count_b, running_b, done_b});
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs(k) !== exp_v(k)) begin
        failures++;
        $display("FAIL t6_after_reset dut%0d got=%h exp=%h", k, obs(k), exp_v(k));
      end
    end
  endtask

  // Randomized traffic against the model, small presets favoured for expiry.
  task automatic test_random();
    logic       c, l, t, p;
    logic [7:0] lv;
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) lv = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      else lv = 8'($urandom);
      t = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 5) == 0);
      cycle(c, l, lv, t, p);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_v(k)) begin
          failures++;
          $display("FAIL rand%0d dut%0d got=%h exp=%h", i, k, obs(k), exp_v(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_auto_reload();
    test_clamp();
    test_load_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
